// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - register-file write-port arbiter with B-unit scoreboard and starvation stall
// Optional feature macro: RF_ARB_X0_FILTER_EN (requests targeting x0 are dropped instead of written)
module rf_wr_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_a_vld,
  input  logic            i_a_wr,
  input  logic [4:0]      i_a_rd,
  input  logic [XLEN-1:0] i_a_data,
  input  logic            i_b_vld,
  output logic            o_b_rdy,
  input  logic [4:0]      i_b_rd,
  input  logic [XLEN-1:0] i_b_data,
  input  logic            i_b_issue,
  input  logic [4:0]      i_b_issue_rd,
  output logic            o_stall,
  output logic            o_rf_wr,
  output logic [4:0]      o_rf_rd,
  output logic [XLEN-1:0] o_rf_data,
  output logic [31:0]     o_busy
);

  typedef enum logic {
    S_NORM  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  localparam logic [3:0] LP_STARVE_LIM = 4'(STARVE_MAX - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_starve;
  logic [3:0]      w_starve_nxt;
  logic [31:0]     r_busy;
  logic [31:0]     w_busy_nxt;
  logic            r_rf_wr;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_data;

  logic            w_a_need;
  logic            w_b_req;
  logic            w_b_drop;
  logic            w_grant_a;
  logic            w_grant_b;
  logic            w_stall;
  logic            w_b_rdy;
  logic            w_b_xfer;

  // A competes only when it really writes; B results aimed at x0 can be
  // swallowed without ever taking the port when the filter is built in.
`ifdef RF_ARB_X0_FILTER_EN
  assign w_a_need = i_a_vld & i_a_wr & (i_a_rd != 5'd0);
  assign w_b_req  = i_b_vld & (i_b_rd != 5'd0);
  assign w_b_drop = i_b_vld & (i_b_rd == 5'd0);
`else
  assign w_a_need = i_a_vld & i_a_wr;
  assign w_b_req  = i_b_vld;
  assign w_b_drop = 1'b0;
`endif

  // Grant selection, stall indication, starvation counting and next state
  always_comb begin
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    w_stall      = 1'b0;
    w_state_nxt  = S_NORM;
    w_starve_nxt = r_starve;

    case (r_state)
      S_NORM: begin
        if (w_a_need) begin
          w_grant_a = 1'b1;
        end else if (w_b_req) begin
          w_grant_b = 1'b1;
        end
      end
      S_STALL: begin
        // A is held off by the stall; the slot belongs to B if it is still there.
        w_stall   = 1'b1;
        w_grant_b = w_b_req;
      end
      default: begin
        w_state_nxt = S_NORM;
      end
    endcase

    if (!w_b_req || w_grant_b) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve == LP_STARVE_LIM) begin
      // Out of patience: hold the count and force a stall next cycle.
      w_starve_nxt = r_starve;
      w_state_nxt  = S_STALL;
    end else begin
      w_starve_nxt = r_starve + 4'd1;
    end

    if (rst) begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      w_stall   = 1'b0;
    end
  end

  assign w_b_rdy  = w_grant_b | (w_b_drop & ~rst);
  assign w_b_xfer = i_b_vld & w_b_rdy;

  // Scoreboard update: clear on commit, then set on issue so a same-cycle issue wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_b_xfer) begin
      w_busy_nxt[i_b_rd] = 1'b0;
    end
    if (i_b_issue) begin
      w_busy_nxt[i_b_issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Arbiter state, starvation counter and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_NORM;
      r_starve <= 4'd0;
      r_busy   <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Registered write port: load the winner, or drop the enable and keep address/data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_wr   <= 1'b0;
      r_rf_rd   <= 5'd0;
      r_rf_data <= '0;
    end else if (w_grant_a) begin
      r_rf_wr   <= 1'b1;
      r_rf_rd   <= i_a_rd;
      r_rf_data <= i_a_data;
    end else if (w_grant_b) begin
      r_rf_wr   <= 1'b1;
      r_rf_rd   <= i_b_rd;
      r_rf_data <= i_b_data;
    end else begin
      r_rf_wr   <= 1'b0;
    end
  end

  assign o_b_rdy   = w_b_rdy;
  assign o_stall   = w_stall;
  assign o_rf_wr   = r_rf_wr;
  assign o_rf_rd   = r_rf_rd;
  assign o_rf_data = r_rf_data;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - scoreboard bench for rf_wr_arbiter with a behavioural reference model
module tb_rf_wr_arbiter;
  localparam int XLEN = 32;
  localparam int SM   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_a_vld, i_a_wr;
  logic [4:0]      i_a_rd;
  logic [XLEN-1:0] i_a_data;
  logic            i_b_vld;
  logic            o_b_rdy;
  logic [4:0]      i_b_rd;
  logic [XLEN-1:0] i_b_data;
  logic            i_b_issue;
  logic [4:0]      i_b_issue_rd;
  logic            o_stall, o_rf_wr;
  logic [4:0]      o_rf_rd;
  logic [XLEN-1:0] o_rf_data;
  logic [31:0]     o_busy;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.XLEN(XLEN), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_a_vld(i_a_vld), .i_a_wr(i_a_wr), .i_a_rd(i_a_rd), .i_a_data(i_a_data),
    .i_b_vld(i_b_vld), .o_b_rdy(o_b_rdy), .i_b_rd(i_b_rd), .i_b_data(i_b_data),
    .i_b_issue(i_b_issue), .i_b_issue_rd(i_b_issue_rd),
    .o_stall(o_stall), .o_rf_wr(o_rf_wr), .o_rf_rd(o_rf_rd), .o_rf_data(o_rf_data),
    .o_busy(o_busy)
  );

  typedef struct {
    logic            wr;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [31:0]     busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  bit              m_stall_next;
  int              m_wait;
  bit              m_busy[32];
  logic            m_wr;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  bit              m_b_acked;
  logic            dut_rdy_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; i_a_vld = 1'b0; i_a_wr = 1'b0; i_a_rd = 5'd0; i_a_data = '0;
    i_b_vld = 1'b0; i_b_rd = 5'd0; i_b_data = '0; i_b_issue = 1'b0; i_b_issue_rd = 5'd0;
  endtask

  // Inputs are already applied just after a negedge; evaluate the model,
  // check combinational outputs, queue the expected post-edge state.
  task automatic run_cycle();
    bit in_stall, a_wants, b_comp, b_zero, win_a, win_b, rdy, lost;
    exp_t e;
    #1;
    if (rst) begin
      rdy = 1'b0; in_stall = 1'b0;
      m_stall_next = 1'b0; m_wait = 0;
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_wr = 1'b0; m_rd = 5'd0; m_data = '0;
    end else begin
      in_stall = m_stall_next;
      a_wants  = i_a_vld && i_a_wr;
      b_comp   = i_b_vld;
      b_zero   = 1'b0;
`ifdef RF_ARB_X0_FILTER_EN
      a_wants = a_wants && (i_a_rd != 5'd0);
      b_comp  = i_b_vld && (i_b_rd != 5'd0);
      b_zero  = i_b_vld && (i_b_rd == 5'd0);
`endif
      win_a = !in_stall && a_wants;
      win_b = b_comp && (in_stall || !a_wants);
      rdy   = win_b || b_zero;
      lost  = b_comp && !win_b;
      m_wait = lost ? m_wait + 1 : 0;
      m_stall_next = lost && (m_wait >= SM);
      if (i_b_vld && rdy) m_busy[i_b_rd] = 1'b0;
      if (i_b_issue) m_busy[i_b_issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (win_a) begin
        m_wr = 1'b1; m_rd = i_a_rd; m_data = i_a_data;
      end else if (win_b) begin
        m_wr = 1'b1; m_rd = i_b_rd; m_data = i_b_data;
      end else begin
        m_wr = 1'b0;
      end
    end
    m_b_acked    = rdy;
    dut_rdy_seen = o_b_rdy;
    check("b_rdy", {63'd0, o_b_rdy}, {63'd0, rdy});
    check("stall", {63'd0, o_stall}, {63'd0, in_stall});
    e.wr = m_wr; e.rd = m_rd; e.data = m_data;
    for (int r = 0; r < 32; r++) e.busy[r] = m_busy[r];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare registered outputs against the queued expectation after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_wr",   {63'd0, o_rf_wr}, {63'd0, e.wr});
        check("rf_rd",   {59'd0, o_rf_rd}, {59'd0, e.rd});
        check("rf_data", {32'd0, o_rf_data}, {32'd0, e.data});
        check("busy",    {32'd0, o_busy}, {32'd0, e.busy});
      end
    end
  end

  initial begin
    int ack_at;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);

    // reset with every input active
    i_a_vld = 1; i_a_wr = 1; i_a_rd = 5'd4; i_a_data = 32'h1111_2222;
    i_b_vld = 1; i_b_rd = 5'd6; i_b_data = 32'h3333; i_b_issue = 1; i_b_issue_rd = 5'd8;
    repeat (3) run_cycle();
    idle_inputs();
    run_cycle();

    // A only, then a non-writing A
    i_a_vld = 1; i_a_wr = 1; i_a_rd = 5'd5; i_a_data = 32'hDEAD_BEEF;
    run_cycle();
    i_a_wr = 0;
    run_cycle();
    idle_inputs();
    run_cycle();

    // collision: A hogs the port, B must win through the forced stall
    i_a_vld = 1; i_a_wr = 1; i_a_rd = 5'd3; i_a_data = 32'hA0A0_0003;
    i_b_vld = 1; i_b_rd = 5'd7; i_b_data = 32'h12;
    ack_at = -1;
    for (int c = 0; c < 8; c++) begin
      run_cycle();
      if (dut_rdy_seen && ack_at < 0) ack_at = c;
      if (m_b_acked) i_b_vld = 0;
    end
    check("collision_ack_cycle", 64'(ack_at), 64'd4);

    // B drops valid during the stall cycle
    i_b_vld = 1; i_b_rd = 5'd11; i_b_data = 32'h55;
    repeat (4) run_cycle();
    i_b_vld = 0;
    run_cycle();
    run_cycle();

    // idle slot: store on A, B takes the port at once
    idle_inputs();
    i_a_vld = 1; i_a_wr = 0; i_a_rd = 5'd2;
    i_b_vld = 1; i_b_rd = 5'd9; i_b_data = 32'h99;
    run_cycle();
    idle_inputs();

    // scoreboard: issue, simultaneous commit+issue, issue to x0
    i_b_issue = 1; i_b_issue_rd = 5'd9;
    run_cycle();
    i_b_vld = 1; i_b_rd = 5'd9; i_b_data = 32'h909;
    run_cycle();
    idle_inputs();
    i_b_issue = 1; i_b_issue_rd = 5'd0;
    run_cycle();
    idle_inputs();
    i_b_vld = 1; i_b_rd = 5'd9; i_b_data = 32'h9;
    run_cycle();
    idle_inputs();
    run_cycle();

    // reset in the middle of starvation with busy bits set
    i_b_issue = 1; i_b_issue_rd = 5'd12;
    run_cycle();
    i_b_issue_rd = 5'd13;
    i_a_vld = 1; i_a_wr = 1; i_a_rd = 5'd1; i_a_data = 32'h1;
    i_b_vld = 1; i_b_rd = 5'd12; i_b_data = 32'hC;
    repeat (2) run_cycle();
    i_b_issue = 0;
    rst = 1;
    run_cycle();
    rst = 0;
    repeat (6) begin
      run_cycle();
      if (m_b_acked) i_b_vld = 0;
    end
    idle_inputs();

    // randomized traffic respecting the B hold-until-accepted rule
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      i_a_vld  = ($urandom_range(0, 9) < 7);
      i_a_wr   = ($urandom_range(0, 9) < 8);
      i_a_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      i_a_data = $urandom;
      if (!i_b_vld && $urandom_range(0, 9) < 4) begin
        i_b_vld  = 1;
        i_b_rd   = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        i_b_data = $urandom;
      end else if (i_b_vld && $urandom_range(0, 49) == 0) begin
        i_b_vld = 0;
      end
      i_b_issue    = ($urandom_range(0, 3) == 0);
      i_b_issue_rd = 5'($urandom_range(0, 31));
      run_cycle();
      if (m_b_acked || rst) i_b_vld = 0;
    end

    idle_inputs();
    run_cycle();
    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
